jtcps2_oram_dma: RTL
====================

JTCPS2_ORAM_DMA -- requirements
Module: jtcps2_oram_dma

Interface
REQ-001 Parameter VB_LINE, default 9'd240: vdump line that triggers the per-frame object-table copy.
REQ-002 Parameter ENTRIES, default 1024: object entries per table; 4 words each (x, y, code, attr).
REQ-003 Ports below; one clock; reset is asynchronous and active-high.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 clk  in  1  system/GFX clock.
REQ-006 pxl_cen  in  1  pixel clock enable; qualifies vdump sampling.
REQ-007 vdump  in  9  current display line.
REQ-008 obank  in  1  CPU-selected ORAM bank.
REQ-009 oram_addr  out  13  SDRAM word address {bank, word[11:0]}.
REQ-010 oram_cs  out  1  SDRAM read request.
REQ-011 oram_ok  in  1  SDRAM data valid.
REQ-012 oram_data  in  16  SDRAM read data.
REQ-013 wr_addr  out  12  shadow-table word address.
REQ-014 wr_data  out  16  shadow-table write data.
REQ-015 wr_en  out  1  shadow-table write strobe, one clk per word.
REQ-016 frame_bank  out  1  shadow half read by the scan engine; writes go to the other half.
REQ-017 busy  out  1  copy in progress.
REQ-018 done  out  1  one-clk pulse when a copy completes and frame_bank toggles.

Function
REQ-019 Trigger: on a pxl_cen cycle where vdump==VB_LINE and the previous sampled vdump!=VB_LINE; fires once per frame.
REQ-020 On trigger: latch obank into bank_l; clear word counter; enter REQ.
REQ-021 States: IDLE, REQ, WAIT, WRITE, FLIP.
REQ-022 REQ: assert oram_cs, oram_addr={bank_l,cnt}; next state WAIT.
REQ-023 WAIT: hold oram_cs and address; oram_ok is ignored in the first cycle after entering REQ (stale ok); on later oram_ok=1, capture oram_data and go to WRITE.
REQ-024 WRITE: wr_en=1, wr_addr=cnt, wr_data=captured word, oram_cs=0; cnt+1; next REQ, or FLIP if end condition.
REQ-025 End condition: cnt==4*ENTRIES-1, or cnt[1:0]==2'd3 and entry's y word (offset 1) bit 15 set (end-of-list marker); remaining words are not copied.
REQ-026 FLIP: toggle frame_bank, pulse done one clk, return to IDLE; busy=0.
REQ-027 busy=1 in every state except IDLE.
REQ-028 Trigger while busy: abort current copy, no frame_bank toggle, no done, restart at cnt=0 with newly latched obank.
REQ-029 obank changes during a copy are ignored until the next trigger.
REQ-030 oram_cs and wr_en never asserted in the same cycle.
REQ-031 Counter is 12 bits; no wrap past 4*ENTRIES-1.

Reset
REQ-032 Reset: state IDLE; oram_cs=0, wr_en=0, done=0, busy=0, frame_bank=0, oram_addr=0, wr_addr=0, wr_data=0, cnt=0, bank_l=0, previous-vdump register=0.
REQ-033 Reset asserted mid-copy returns to reset values immediately; no partial toggle.

Structure
REQ-034 State encoding and word-offset constants (X=0, Y=1, CODE=2, ATTR=3) in shared package jtcps2_obj_pkg.
REQ-035 Single module; trigger edge detector may be a sub-module jtcps2_line_trig.

Verification
REQ-036 Full copy: obank=1, oram_ok 2 clk after cs, no markers -> 4096 writes, addresses 0x1000-0x1FFF read, frame_bank 0->1, one done pulse.
REQ-037 End marker: y word of entry 5 = 0x8000 -> last write wr_addr=23, frame_bank toggles, no further oram_cs.
REQ-038 Stale ok: oram_ok held high constantly -> each word still takes >=3 clk; data sampled from second WAIT cycle.
REQ-039 Re-trigger: copy stalled (oram_ok=0) across next VB_LINE -> restart at addr 0, frame_bank unchanged, no done.
REQ-040 Mid-copy reset at word 100 -> all outputs reset values; next trigger starts at word 0.
REQ-041 vdump held at VB_LINE across many pxl_cen -> exactly one trigger.

Source files
------------

// File: rtl/jtcps2_obj_pkg.sv
// Shared constants for the CPS2 object-RAM copy engine: FSM encoding and
// word offsets inside a 4-word object entry.
package jtcps2_obj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FLIP  = 3'd4
  } obj_dma_st_t;

  localparam logic [1:0] OFS_X    = 2'd0;
  localparam logic [1:0] OFS_Y    = 2'd1;
  localparam logic [1:0] OFS_CODE = 2'd2;
  localparam logic [1:0] OFS_ATTR = 2'd3;

  // Bit of the y word that marks the last valid entry of the list.
  localparam int Y_END_BIT = 15;

endpackage

// File: rtl/jtcps2_line_trig.sv
// Rising-edge detector on "vdump reached VB_LINE", sampled on pixel enables,
// so a line held for many pixels yields a single trigger.
module jtcps2_line_trig #(
  parameter logic [8:0] VB_LINE = 9'd240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic [8:0] vdump,
  output logic       trig
);

  logic [8:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else if (pxl_cen) begin
      prev_q <= vdump;
    end
  end

  assign trig = pxl_cen && (vdump == VB_LINE) && (prev_q != VB_LINE);

endmodule

// File: rtl/jtcps2_oram_dma.sv
// Per-frame copy of the CPU object table from SDRAM into the off-screen half
// of a double-buffered shadow table; the halves swap when a copy completes.
module jtcps2_oram_dma
  import jtcps2_obj_pkg::*;
#(
  parameter logic [8:0] VB_LINE = 9'd240,
  parameter int         ENTRIES = 1024
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        pxl_cen,
  input  logic [8:0]  vdump,
  input  logic        obank,
  output logic [12:0] oram_addr,
  output logic        oram_cs,
  input  logic        oram_ok,
  input  logic [15:0] oram_data,
  output logic [11:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        frame_bank,
  output logic        busy,
  output logic        done
);

  localparam logic [11:0] LAST_WORD = 12'(4 * ENTRIES - 1);

  obj_dma_st_t state_q, state_d;
  logic        trig;
  logic [11:0] cnt_q;
  logic        bank_q;
  logic [15:0] data_q;
  logic        mark_q;
  logic        wait_first_q;
  logic        fb_q;
  logic        end_cond;

  jtcps2_line_trig #(
    .VB_LINE (VB_LINE)
  ) u_trig (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .vdump   (vdump),
    .trig    (trig)
  );

  // Stop at the table end, or after the attr word of an entry whose y word
  // carried the end-of-list marker.
  assign end_cond = (cnt_q == LAST_WORD) || ((cnt_q[1:0] == OFS_ATTR) && mark_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // SDRAM handshake: oram_cs stays high with a stable address until oram_ok
  // is seen; ok in the first WAIT cycle may belong to the previous request
  // and is discarded.
  always_comb begin
    state_d = state_q;
    if (trig) begin
      state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_REQ:   state_d = ST_WAIT;
        ST_WAIT:  if (!wait_first_q && oram_ok) state_d = ST_WRITE;
        ST_WRITE: state_d = end_cond ? ST_FLIP : ST_REQ;
        ST_FLIP:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    oram_cs    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    wr_en      = (state_q == ST_WRITE);
    done       = (state_q == ST_FLIP) && !trig;
    busy       = (state_q != ST_IDLE);
    oram_addr  = {bank_q, cnt_q};
    wr_addr    = cnt_q;
    wr_data    = data_q;
    frame_bank = fb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      bank_q       <= 1'b0;
      data_q       <= '0;
      mark_q       <= 1'b0;
      wait_first_q <= 1'b0;
      fb_q         <= 1'b0;
    end else if (trig) begin
      // A new trigger always restarts from word 0, abandoning any copy.
      cnt_q        <= '0;
      bank_q       <= obank;
      mark_q       <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      case (state_q)
        ST_REQ: wait_first_q <= 1'b1;
        ST_WAIT: begin
          wait_first_q <= 1'b0;
          if (!wait_first_q && oram_ok) begin
            data_q <= oram_data;
            if (cnt_q[1:0] == OFS_Y) mark_q <= oram_data[Y_END_BIT];
          end
        end
        ST_WRITE: if (!end_cond) cnt_q <= cnt_q + 12'd1;
        ST_FLIP:  fb_q <= ~fb_q;
        default: ;
      endcase
    end
  end

endmodule
